gray_updown_counter: RTL
========================

# gray_updown_counter

Parametrised up/down counter whose state register holds Gray code. The block also presents the count in binary and provides a pipelined Gray-to-binary conversion channel. It is the sequential successor to the 4-bit combinational Gray-to-binary converter. It serves as a position/pointer source wherever only one bit may change per step, such as FIFO pointers or encoder emulation.

## Interface
Parameters:
- WIDTH, 4: counter and converter width in bits; legal range is 2 to 16.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- en  in  1  count enable; one step per cycle while high.
- up  in  1  direction: 1 counts up, 0 counts down (in binary order).
- load  in  1  synchronous load of D.
- load_gray  in  1  D encoding for load: 1 means Gray, 0 means binary.
- D  in  WIDTH  load value.
- GRAY  out  WIDTH  counter state, Gray-coded, registered.
- BIN  out  WIDTH  binary equivalent of GRAY, registered, cycle-coincident with GRAY.
- wrap  out  1  one-cycle pulse on the cycle GRAY shows a wrapped value.
- CONV_IN  in  WIDTH  Gray word for the standalone converter.
- CONV_VLD  in  1  CONV_IN valid.
- CONV_OUT  out  WIDTH  binary of the last valid CONV_IN, registered.
- CONV_OVLD  out  1  CONV_OUT valid; it is CONV_VLD delayed by 1 cycle.

## Operation
- Priority per edge is rst > load > en. When none of these is active, all state holds.
- rst: GRAY, BIN, CONV_OUT = 0; wrap, CONV_OVLD = 0.
- load with load_gray=1:
  - GRAY <= D.
  - BIN <= gray2bin(D).
- load with load_gray=0:
  - BIN <= D.
  - GRAY <= D ^ (D >> 1).
- On a load cycle, wrap <= 0 regardless of en.
- en, up=1:
  - next binary is BIN+1, modulo 2^WIDTH.
  - GRAY <= bin2gray(next).
  - wrap <= 1 if and only if BIN was all-ones.
- en, up=0:
  - next binary is BIN-1, modulo 2^WIDTH.
  - wrap <= 1 if and only if BIN was 0.
- In every other cycle, wrap <= 0.
- Every count step changes exactly one bit of GRAY, including across the wrap.
- Gray-to-binary rule: b[WIDTH-1] = g[WIDTH-1]; b[i] = b[i+1] ^ g[i].
- Converter channel:
  - when CONV_VLD=1, CONV_OUT <= gray2bin(CONV_IN).
  - when CONV_VLD=0, CONV_OUT holds.
  - CONV_OVLD <= CONV_VLD every cycle.
  - The channel is independent of the counter; both operate every cycle.
- BIN is a register, not combinational from GRAY, and always equals gray2bin(GRAY). This invariant is checked by an assertion.

## Timing
- Latency from load, en or rst to GRAY/BIN/wrap is 1 cycle; the effect is visible after the next rising edge.
- Converter latency is 1 cycle. Back-to-back valid words are accepted every cycle; there is no backpressure.
- Simultaneous load and en: load wins and the count step is dropped.
- rst during a count or conversion: all outputs read 0 after that edge, and any in-flight converter valid is dropped.
- Direction change takes effect on the same edge it is sampled; there is no turnaround cycle.
- en held through a wrap: wrap is high for exactly the one wrapped cycle.

## Structure
- Package gray_pkg holds the functions gray2bin(WIDTH) and bin2gray(WIDTH).
- A sub-module gray2bin_comb is natural: a parametrised combinational XOR chain. It is instantiated twice: once in the load path, and once in the converter channel.
- The counter core is a single always block with the priority mux, plus the output registers.

## Test plan
Each scenario uses WIDTH=4:
1. Release rst, hold en=1, up=1 for 17 cycles.
   - GRAY sequence: 0000, 0001, 0011, 0010, 0110, … 1000, 0000.
   - BIN runs 0..15, then 0.
   - wrap is high only at the final 0000.
2. From reset, step en=1, up=0 for one cycle.
   - GRAY=1000, BIN=1111, wrap=1.
   - On the next down step: GRAY=1001, BIN=1110, wrap=0.
3. Load tests:
   - load=1, load_gray=1, D=1010 → GRAY=1010, BIN=1100.
   - load=1, load_gray=0, D=0101 → GRAY=0111, BIN=0101.
4. Apply load=1, en=1, up=1, D=0011 (binary) in the same cycle.
   - Response: BIN=0011, GRAY=0010, wrap=0; no increment.
5. Count to BIN=0110, then assert rst for one cycle alongside en=1.
   - All outputs read 0.
   - Counting resumes from 0001 after rst drops.
6. Converter stream: CONV_IN 1001, 1000, 0110 with CONV_VLD=1 on consecutive cycles, then CONV_VLD=0.
   - CONV_OUT is 1110, 1111, 0100 one cycle later each.
   - CONV_OVLD is high for 3 cycles.
   - CONV_OUT then holds at 0100.
   - A random 30-vector run checks both GRAY-vs-BIN and the converter against the golden model.

Source files
------------

// File: rtl/gray_pkg.sv
// Shared Gray/binary helpers for the counter slice. Functions operate on a
// MAX_WIDTH word; narrower values are zero-extended, which leaves results intact.
package gray_pkg;

  localparam int MAX_WIDTH = 16;

  typedef logic [MAX_WIDTH-1:0] word_t;

  function automatic word_t bin2gray(input word_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic word_t gray2bin(input word_t g);
    word_t b;
    b[MAX_WIDTH-1] = g[MAX_WIDTH-1];
    for (int i = MAX_WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray2bin_comb.sv
// Parametrised combinational Gray-to-binary XOR chain, MSB passes straight through.
module gray2bin_comb #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  assign bin[WIDTH-1] = gray[WIDTH-1];

  for (genvar gi = WIDTH - 2; gi >= 0; gi--) begin : g_chain
    assign bin[gi] = bin[gi+1] ^ gray[gi];
  end

endmodule

// File: rtl/gray_updown_counter.sv
// Up/down counter with Gray-coded state, registered binary mirror, wrap pulse
// and an independent one-cycle Gray-to-binary conversion channel.
module gray_updown_counter
  import gray_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic             load_gray,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] GRAY,
  output logic [WIDTH-1:0] BIN,
  output logic             wrap,
  input  logic [WIDTH-1:0] CONV_IN,
  input  logic             CONV_VLD,
  output logic [WIDTH-1:0] CONV_OUT,
  output logic             CONV_OVLD
);

  logic [WIDTH-1:0] gray_reg, gray_next;
  logic [WIDTH-1:0] bin_reg, bin_next;
  logic             wrap_reg, wrap_next;
  logic [WIDTH-1:0] conv_out_reg;
  logic             conv_ovld_reg;

  logic [WIDTH-1:0] d_bin;
  logic [WIDTH-1:0] conv_bin;
  word_t            gray_wide;

  gray2bin_comb #(.WIDTH(WIDTH)) u_load_conv (
    .gray (D),
    .bin  (d_bin)
  );

  gray2bin_comb #(.WIDTH(WIDTH)) u_chan_conv (
    .gray (CONV_IN),
    .bin  (conv_bin)
  );

  // Gray is always derived from the next binary value, so a count step flips one bit.
  assign gray_wide = bin2gray(word_t'(bin_next));

  always_comb begin
    bin_next  = bin_reg;
    gray_next = gray_reg;
    wrap_next = 1'b0;
    if (load) begin
      bin_next  = load_gray ? d_bin : D;
      gray_next = load_gray ? D : gray_wide[WIDTH-1:0];
    end else if (en) begin
      if (up) begin
        bin_next  = bin_reg + 1'b1;
        wrap_next = &bin_reg;
      end else begin
        bin_next  = bin_reg - 1'b1;
        wrap_next = ~|bin_reg;
      end
      gray_next = gray_wide[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gray_reg      <= '0;
      bin_reg       <= '0;
      wrap_reg      <= 1'b0;
      conv_out_reg  <= '0;
      conv_ovld_reg <= 1'b0;
    end else begin
      gray_reg      <= gray_next;
      bin_reg       <= bin_next;
      wrap_reg      <= wrap_next;
      conv_ovld_reg <= CONV_VLD;
      if (CONV_VLD) begin
        conv_out_reg <= conv_bin;
      end
    end
  end

  assign GRAY      = gray_reg;
  assign BIN       = bin_reg;
  assign wrap      = wrap_reg;
  assign CONV_OUT  = conv_out_reg;
  assign CONV_OVLD = conv_ovld_reg;

  word_t bin_of_gray_wide;
  assign bin_of_gray_wide = gray2bin(word_t'(gray_reg));

  bin_matches_gray: assert property (@(posedge clk) disable iff (rst)
    bin_reg == bin_of_gray_wide[WIDTH-1:0]);

endmodule
